// File: rtl/wb_merge_stage_if.sv
// Purpose : bundles the writeback-stage pipeline inputs, the long-latency result
//           channel and the register-file write port into one connection.
// Ports   : slave = wb_merge_stage side, master = upstream pipeline / RF side.
// Flow    : ll_* is valid/ready; stall_o holds the pipeline WB instruction.
interface wb_merge_stage_if #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 4
);
   // pipeline writeback instruction
   logic                     wb_valid_i;
   logic                     wb_mem_to_reg_i;
   logic                     wb_jump_i;
   logic [2:0]               wb_funct3_i;
   logic [XLEN-1:0]          wb_alu_result_i;
   logic [XLEN-1:0]          wb_read_data_i;
   logic [XLEN-1:0]          wb_pc_plus4_i;
   logic [4:0]               wb_rd_i;
   // long-latency result channel
   logic                     ll_valid_i;
   logic                     ll_ready_o;
   logic [XLEN-1:0]          ll_result_i;
   logic [4:0]               ll_rd_i;
   // stall and register-file write port
   logic                     stall_o;
   logic                     rf_we_o;
   logic [4:0]               rf_waddr_o;
   logic [XLEN-1:0]          rf_wdata_o;
   logic [$clog2(DEPTH):0]   buf_count_o;

   modport slave (
      input  wb_valid_i, wb_mem_to_reg_i, wb_jump_i, wb_funct3_i,
             wb_alu_result_i, wb_read_data_i, wb_pc_plus4_i, wb_rd_i,
             ll_valid_i, ll_result_i, ll_rd_i,
      output ll_ready_o, stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, buf_count_o
   );

   modport master (
      output wb_valid_i, wb_mem_to_reg_i, wb_jump_i, wb_funct3_i,
             wb_alu_result_i, wb_read_data_i, wb_pc_plus4_i, wb_rd_i,
             ll_valid_i, ll_result_i, ll_rd_i,
      input  ll_ready_o, stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, buf_count_o
   );
endinterface

// File: rtl/wb_merge_stage.sv
// Purpose : writeback stage merging the pipeline result and a buffered long-latency
//           result channel into one registered RF write port, with load extraction.
// Latency : pipeline result written 1 edge after presentation; ll result >= 2 edges.
// Backpr. : ll_ready_o drops when the FIFO is full; stall_o holds the WB instruction
//           for one cycle when the FIFO head has waited STARVE_LIMIT cycles.
// Ports   : clk, rst_n (sync, active-low), bus (wb_merge_stage_if.slave).

// Small generic synchronous FIFO. No bypass: the head reflects registered state only.
// Caller must not pop when empty nor push when full.
module wb_merge_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic [W-1:0]            push_dat,
   input  logic                    pop,
   output logic [W-1:0]            head_dat,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read once counted as valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   assign head_dat = mem[rd_ptr];
endmodule

module wb_merge_stage #(
   parameter int XLEN         = 64,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   wb_merge_stage_if.slave    bus
);
   localparam int OFFW  = $clog2(XLEN/8);
   localparam int CNTW  = $clog2(DEPTH) + 1;
   localparam int WAITW = $clog2(STARVE_LIMIT + 1);
   localparam int EW    = XLEN + 5;

   localparam logic [CNTW-1:0]  DEPTH_C = CNTW'(DEPTH);
   localparam logic [WAITW-1:0] LIMIT_C = WAITW'(STARVE_LIMIT);
   localparam logic [WAITW-1:0] WAIT_ONE = WAITW'(1);

   // ------------------------------------------------------------------
   // Load extraction
   // ------------------------------------------------------------------
   logic [OFFW-1:0] off_b;
   logic [OFFW-1:0] off_h;
   logic [OFFW-1:0] off_w;
   logic [7:0]      ld_b;
   logic [15:0]     ld_h;
   logic [31:0]     ld_w;
   logic [XLEN-1:0] lw_val;
   logic [XLEN-1:0] load_val;

   always_comb begin
      // Sub-size offset bits are masked off: accesses are assumed aligned.
      off_b  = bus.wb_alu_result_i[OFFW-1:0];
      off_h  = off_b & ~OFFW'(1);
      off_w  = off_b & ~OFFW'(3);
      ld_b   = 8'(bus.wb_read_data_i  >> {off_b, 3'b000});
      ld_h   = 16'(bus.wb_read_data_i >> {off_h, 3'b000});
      ld_w   = 32'(bus.wb_read_data_i >> {off_w, 3'b000});
      lw_val = XLEN'($signed(ld_w));
      load_val = lw_val;
      case (bus.wb_funct3_i)
         3'b000:  load_val = XLEN'($signed(ld_b));
         3'b001:  load_val = XLEN'($signed(ld_h));
         3'b010:  load_val = lw_val;
         // LD / LWU only exist on RV64; on RV32 they fall back to LW data.
         3'b011:  load_val = (XLEN == 64) ? bus.wb_read_data_i : lw_val;
         3'b100:  load_val = XLEN'(ld_b);
         3'b101:  load_val = XLEN'(ld_h);
         3'b110:  load_val = (XLEN == 64) ? XLEN'(ld_w) : lw_val;
         default: load_val = lw_val;
      endcase
   end

   // ------------------------------------------------------------------
   // Pipeline data select (jump overrides mem_to_reg)
   // ------------------------------------------------------------------
   logic [XLEN-1:0] wb_data;

   always_comb begin
      if (bus.wb_jump_i)
         wb_data = bus.wb_pc_plus4_i;
      else if (bus.wb_mem_to_reg_i)
         wb_data = load_val;
      else
         wb_data = bus.wb_alu_result_i;
   end

   // ------------------------------------------------------------------
   // Long-latency FIFO
   // ------------------------------------------------------------------
   logic            fifo_push;
   logic            fifo_pop;
   logic [EW-1:0]   fifo_head;
   logic [CNTW-1:0] fifo_count;
   logic            fifo_empty;
   logic            ll_ready;
   logic            wb_wr;
   logic            stall;
   logic [WAITW-1:0] wait_cnt;

   assign fifo_empty = (fifo_count == '0);
   // Ready uses the registered count only, so a same-cycle pop never raises it.
   assign ll_ready   = rst_n && (fifo_count < DEPTH_C);
   // rd=0 results are accepted (handshake completes) but have nothing to write.
   assign fifo_push  = bus.ll_valid_i && ll_ready && (bus.ll_rd_i != 5'd0);
   assign wb_wr      = bus.wb_valid_i && (bus.wb_rd_i != 5'd0);
   assign stall      = rst_n && (wait_cnt == LIMIT_C);
   // Stall implies a non-empty FIFO, since the wait counter only runs while occupied.
   assign fifo_pop   = !fifo_empty && (stall || !wb_wr);

   wb_merge_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (fifo_push),
      .push_dat ({bus.ll_rd_i, bus.ll_result_i}),
      .pop      (fifo_pop),
      .head_dat (fifo_head),
      .count    (fifo_count)
   );

   // ------------------------------------------------------------------
   // Anti-starvation counter: counts cycles the head is left waiting.
   // Reaching the limit forces a pop, which clears it, so stall lasts one cycle.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n)
         wait_cnt <= '0;
      else if (fifo_pop || fifo_empty)
         wait_cnt <= '0;
      else
         wait_cnt <= wait_cnt + WAIT_ONE;
   end

   // ------------------------------------------------------------------
   // Registered RF write port
   // ------------------------------------------------------------------
   logic            rf_we_q;
   logic [4:0]      rf_waddr_q;
   logic [XLEN-1:0] rf_wdata_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else if (stall) begin
         rf_we_q    <= 1'b1;
         rf_waddr_q <= fifo_head[EW-1:XLEN];
         rf_wdata_q <= fifo_head[XLEN-1:0];
      end else if (wb_wr) begin
         rf_we_q    <= 1'b1;
         rf_waddr_q <= bus.wb_rd_i;
         rf_wdata_q <= wb_data;
      end else if (fifo_pop) begin
         rf_we_q    <= 1'b1;
         rf_waddr_q <= fifo_head[EW-1:XLEN];
         rf_wdata_q <= fifo_head[XLEN-1:0];
      end else begin
         // Address/data hold so the RF port toggles only on real writes.
         rf_we_q    <= 1'b0;
      end
   end

   assign bus.ll_ready_o  = ll_ready;
   assign bus.stall_o     = stall;
   assign bus.rf_we_o     = rf_we_q;
   assign bus.rf_waddr_o  = rf_waddr_q;
   assign bus.rf_wdata_o  = rf_wdata_q;
   assign bus.buf_count_o = fifo_count;
endmodule

// File: tb/tb_wb_merge_stage.sv
// Directed bench for wb_merge_stage (XLEN=64, DEPTH=4, STARVE_LIMIT=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_wb_merge_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   wb_merge_stage_if #(.XLEN(64), .DEPTH(4)) bus ();

   wb_merge_stage #(.XLEN(64), .DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_wb(input logic v, input logic m2r, input logic jmp, input logic [2:0] f3,
                         input logic [63:0] alu, input logic [63:0] rdat,
                         input logic [63:0] pc4, input logic [4:0] rd);
      bus.wb_valid_i      = v;
      bus.wb_mem_to_reg_i = m2r;
      bus.wb_jump_i       = jmp;
      bus.wb_funct3_i     = f3;
      bus.wb_alu_result_i = alu;
      bus.wb_read_data_i  = rdat;
      bus.wb_pc_plus4_i   = pc4;
      bus.wb_rd_i         = rd;
   endtask

   task automatic set_ll(input logic v, input logic [63:0] res, input logic [4:0] rd);
      bus.ll_valid_i  = v;
      bus.ll_result_i = res;
      bus.ll_rd_i     = rd;
   endtask

   task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [63:0] dat);
      chk({tag, "_we"},    bus.rf_we_o,    1);
      chk({tag, "_waddr"}, bus.rf_waddr_o, rd);
      chk({tag, "_wdata"}, bus.rf_wdata_o, dat);
   endtask

   initial begin
      set_wb(0, 0, 0, 3'd0, 64'd0, 64'd0, 64'd0, 5'd0);
      set_ll(0, 64'd0, 5'd0);

      // ---------------- reset state ----------------
      step(); step();
      chk("rst_we",    bus.rf_we_o, 0);
      chk("rst_waddr", bus.rf_waddr_o, 0);
      chk("rst_wdata", bus.rf_wdata_o, 0);
      chk("rst_count", bus.buf_count_o, 0);
      chk("rst_ready", bus.ll_ready_o, 0);
      chk("rst_stall", bus.stall_o, 0);
      rst_n = 1'b1;
      step();
      chk("post_rst_ready", bus.ll_ready_o, 1);
      chk("post_rst_we", bus.rf_we_o, 0);

      // ---------------- load extraction / data select ----------------
      set_wb(1, 1, 0, 3'b000, 64'h0, 64'h0000_0000_8001_0080, 64'h0, 5'd1); step();
      chk_wr("lb", 5'd1, 64'hFFFF_FFFF_FFFF_FF80);
      set_wb(1, 1, 0, 3'b100, 64'h0, 64'h0000_0000_8001_0080, 64'h0, 5'd2); step();
      chk_wr("lbu", 5'd2, 64'h80);
      set_wb(1, 1, 0, 3'b001, 64'h2, 64'h0000_0000_8001_0080, 64'h0, 5'd3); step();
      chk_wr("lh", 5'd3, 64'hFFFF_FFFF_FFFF_8001);
      set_wb(1, 1, 1, 3'b000, 64'h0, 64'h0000_0000_8001_0080, 64'h1004, 5'd4); step();
      chk_wr("jump", 5'd4, 64'h1004);
      set_wb(1, 1, 0, 3'b010, 64'h4, 64'hF000_0001_0000_0000, 64'h0, 5'd8); step();
      chk_wr("lw", 5'd8, 64'hFFFF_FFFF_F000_0001);
      set_wb(1, 1, 0, 3'b110, 64'h4, 64'hF000_0001_0000_0000, 64'h0, 5'd9); step();
      chk_wr("lwu", 5'd9, 64'h0000_0000_F000_0001);
      set_wb(1, 1, 0, 3'b011, 64'h0, 64'hF000_0001_0000_0002, 64'h0, 5'd10); step();
      chk_wr("ld", 5'd10, 64'hF000_0001_0000_0002);
      set_wb(1, 0, 0, 3'b000, 64'h1234_5678_9ABC_DEF0, 64'h0, 64'h0, 5'd6); step();
      chk_wr("alu", 5'd6, 64'h1234_5678_9ABC_DEF0);
      set_wb(0, 0, 0, 3'd0, 64'h0, 64'h0, 64'h0, 5'd0); step();
      chk("idle_we", bus.rf_we_o, 0);
      chk("idle_hold_waddr", bus.rf_waddr_o, 6);
      chk("idle_hold_wdata", bus.rf_wdata_o, 64'h1234_5678_9ABC_DEF0);

      // ---------------- simultaneous wb and ll ----------------
      set_wb(1, 0, 0, 3'd0, 64'h55, 64'h0, 64'h0, 5'd5);
      set_ll(1, 64'h77, 5'd7);
      step();
      chk_wr("same_wb", 5'd5, 64'h55);
      chk("same_count1", bus.buf_count_o, 1);
      set_wb(0, 0, 0, 3'd0, 64'h0, 64'h0, 64'h0, 5'd0);
      set_ll(0, 64'h0, 5'd0);
      step();
      chk_wr("same_ll", 5'd7, 64'h77);
      chk("same_count0", bus.buf_count_o, 0);

      // ---------------- rd=0 handling ----------------
      set_wb(1, 0, 0, 3'd0, 64'hA, 64'h0, 64'h0, 5'd10);
      set_ll(1, 64'h99, 5'd9);
      step();
      chk_wr("rd0_pre", 5'd10, 64'hA);
      chk("rd0_count1", bus.buf_count_o, 1);
      set_wb(1, 0, 0, 3'd0, 64'hBAD, 64'h0, 64'h0, 5'd0);
      set_ll(1, 64'hDEAD, 5'd0);
      chk("rd0_ready", bus.ll_ready_o, 1);
      step();
      chk_wr("rd0_drain", 5'd9, 64'h99);
      chk("rd0_count0", bus.buf_count_o, 0);
      set_wb(0, 0, 0, 3'd0, 64'h0, 64'h0, 64'h0, 5'd0);
      set_ll(0, 64'h0, 5'd0);
      step();
      chk("rd0_nowrite", bus.rf_we_o, 0);
      chk("rd0_count_end", bus.buf_count_o, 0);

      // ---------------- starvation: accept at E0, stall after E8 ----------------
      set_wb(1, 0, 0, 3'd0, 64'h100, 64'h0, 64'h0, 5'd11);
      set_ll(1, 64'hC0, 5'd12);
      step();                                   // E0
      chk_wr("starve_e0", 5'd11, 64'h100);
      set_ll(0, 64'h0, 5'd0);
      for (int k = 1; k <= 8; k++) begin
         step();                                // Ek
         chk($sformatf("starve_stall_e%0d", k), bus.stall_o, (k == 8));
         chk($sformatf("starve_waddr_e%0d", k), bus.rf_waddr_o, 11);
         bus.wb_alu_result_i = 64'h100 + 64'(k);
      end
      chk("starve_e8_wdata", bus.rf_wdata_o, 64'h107);
      step();                                   // E9
      chk_wr("starve_e9", 5'd12, 64'hC0);
      chk("starve_e9_stall", bus.stall_o, 0);
      step();                                   // E10
      chk_wr("starve_e10", 5'd11, 64'h108);
      chk("starve_e10_count", bus.buf_count_o, 0);

      // ---------------- FIFO full / ordering ----------------
      set_wb(1, 0, 0, 3'd0, 64'h13, 64'h0, 64'h0, 5'd13);
      set_ll(1, 64'hD0, 5'd16);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("full_count%0d", i), bus.buf_count_o, 64'(i + 1));
         set_ll(1, 64'hD1 + 64'(i), 5'(17 + i));
      end
      chk("full_ready", bus.ll_ready_o, 0);
      for (int k = 4; k <= 8; k++) begin
         step();
         chk($sformatf("full_hold_count%0d", k), bus.buf_count_o, 4);
         chk($sformatf("full_hold_ready%0d", k), bus.ll_ready_o, 0);
      end
      chk("full_stall", bus.stall_o, 1);
      step();                                   // forced pop, 5th still held
      chk_wr("full_pop0", 5'd16, 64'hD0);
      chk("full_count_after_pop", bus.buf_count_o, 3);
      chk("full_ready_again", bus.ll_ready_o, 1);
      step();                                   // 5th accepted, wb written
      chk_wr("full_wb", 5'd13, 64'h13);
      chk("full_count_refill", bus.buf_count_o, 4);
      set_wb(0, 0, 0, 3'd0, 64'h0, 64'h0, 64'h0, 5'd0);
      set_ll(0, 64'h0, 5'd0);
      for (int r = 17; r <= 20; r++) begin
         step();
         chk_wr($sformatf("order_x%0d", r), 5'(r), 64'hD0 + 64'(r - 16));
      end
      step();
      chk("drain_we", bus.rf_we_o, 0);
      chk("drain_count", bus.buf_count_o, 0);

      // ---------------- reset mid-stream with 3 entries ----------------
      set_wb(1, 0, 0, 3'd0, 64'h21, 64'h0, 64'h0, 5'd21);
      for (int i = 0; i < 3; i++) begin
         set_ll(1, 64'hE0 + 64'(i), 5'(22 + i));
         step();
      end
      chk("mid_count3", bus.buf_count_o, 3);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready_comb", bus.ll_ready_o, 0);
      chk("mid_rst_stall_comb", bus.stall_o, 0);
      step(); step();
      chk("mid_rst_we", bus.rf_we_o, 0);
      chk("mid_rst_waddr", bus.rf_waddr_o, 0);
      chk("mid_rst_count", bus.buf_count_o, 0);
      chk("mid_rst_ready", bus.ll_ready_o, 0);
      rst_n = 1'b1;
      set_wb(0, 0, 0, 3'd0, 64'h0, 64'h0, 64'h0, 5'd0);
      set_ll(0, 64'h0, 5'd0);
      #1;
      chk("mid_rel_ready", bus.ll_ready_o, 1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("mid_no_stale%0d", k), bus.rf_we_o, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
